sync_fifo_flags: RTL and testbench

Single-clock, parametrised successor to the team's CDC FIFO. It is used wherever producer and consumer share `clk`, so no gray-code pointer crossing is needed. It adds features the CDC FIFO lacks: an exact occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags with a clear, and a selectable first-word-fall-through (FWFT) read mode. It sits behind the Tiny Tapeout top-level pin mapping in the same way as the CDC FIFO.

---
 rtl/sync_fifo_flags.sv | 67 ++++++
 tb/tb_sync_fifo_flags.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with exact count, almost flags, sticky errors and selectable FWFT reads
module sync_fifo_flags #(
   parameter int DATA_WIDTH          = 4,
   parameter int ADDRESS_WIDTH       = 5,
   parameter bit FWFT                = 1'b0,
   parameter int ALMOST_FULL_THRESH  = (1 << ADDRESS_WIDTH) - 4,
   parameter int ALMOST_EMPTY_THRESH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic                    write_increment,
   input  logic                    read_increment,
   input  logic                    clear_errors,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_empty,
   output logic                    almost_full,
   output logic [ADDRESS_WIDTH:0]  count,
   output logic                    overflow,
   output logic                    underflow
);
   localparam int DEPTH = 1 << ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH + 1)'(DEPTH);
   localparam logic [ADDRESS_WIDTH:0] AF_C = (ADDRESS_WIDTH + 1)'(ALMOST_FULL_THRESH);
   localparam logic [ADDRESS_WIDTH:0] AE_C = (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_THRESH);
   localparam logic [ADDRESS_WIDTH:0] CNT_ONE = (ADDRESS_WIDTH + 1)'(1);
   localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);
   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0]    rd_reg;
   logic [ADDRESS_WIDTH:0]   count_next;
   logic                     push, pop;
   assign empty        = count == '0;
   assign full         = count == DEPTH_C;
   assign almost_empty = count <= AE_C;
   assign almost_full  = count >= AF_C;
   assign push         = write_increment && !full;
   assign pop          = read_increment && !empty;
   assign read_data    = FWFT ? mem[rd_ptr] : rd_reg;
   always_comb begin
      count_next = (push && !pop) ? count + CNT_ONE : (pop && !push) ? count - CNT_ONE : count;
   end
   always_ff @(posedge clk) begin
      if (rst_n && push) mem[wr_ptr] <= write_data;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_reg    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            rd_reg <= mem[rd_ptr];
         end
         count     <= count_next;
         overflow  <= (write_increment && full) || (overflow && !clear_errors);
         underflow <= (read_increment && empty) || (underflow && !clear_errors);
      end
   end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: registered-read and FWFT instances driven in lockstep against a queue-based model
module tb_sync_fifo_flags;
   localparam int DEPTH = 32;
   localparam int AF = 28;
   localparam int AE = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] write_data = '0;
   logic write_increment = 1'b0;
   logic read_increment = 1'b0;
   logic clear_errors = 1'b0;
   logic [3:0] rd0, rd1;
   logic empty0, full0, ae0, af0, ovf0, unf0;
   logic empty1, full1, ae1, af1, ovf1, unf1;
   logic [5:0] cnt0, cnt1;
   int total = 0;
   int passed = 0;
   bit chk_en = 1'b0;
   logic [3:0] q[$];
   bit m_ovf, m_unf;
   logic [3:0] m_rd;

   always #5 clk = ~clk;

   sync_fifo_flags #(.FWFT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .write_data(write_data), .write_increment(write_increment),
      .read_increment(read_increment), .clear_errors(clear_errors), .read_data(rd0),
      .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0), .count(cnt0),
      .overflow(ovf0), .underflow(unf0));

   sync_fifo_flags #(.FWFT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .write_data(write_data), .write_increment(write_increment),
      .read_increment(read_increment), .clear_errors(clear_errors), .read_data(rd1),
      .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1), .count(cnt1),
      .overflow(ovf1), .underflow(unf1));

   function automatic void chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rd = '0;
      end else begin
         bit was_full, was_empty;
         was_full = q.size() == DEPTH;
         was_empty = q.size() == 0;
         m_ovf = (write_increment && was_full) || (m_ovf && !clear_errors);
         m_unf = (read_increment && was_empty) || (m_unf && !clear_errors);
         if (read_increment && !was_empty) m_rd = q.pop_front();
         if (write_increment && !was_full) q.push_back(write_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = q.size();
         chk("count0", int'(cnt0), n);
         chk("count1", int'(cnt1), n);
         chk("empty", int'(empty0), int'(n == 0));
         chk("full", int'(full0), int'(n == DEPTH));
         chk("almost_empty", int'(ae0), int'(n <= AE));
         chk("almost_full", int'(af0), int'(n >= AF));
         chk("flags1", int'({empty1, full1, ae1, af1}), int'({empty0 == 1'b1 ? n == 0 : n == 0, n == DEPTH, n <= AE, n >= AF}));
         chk("overflow", int'({ovf0, ovf1}), int'({m_ovf, m_ovf}));
         chk("underflow", int'({unf0, unf1}), int'({m_unf, m_unf}));
         chk("read_data_reg", int'(rd0), int'(m_rd));
         if (n > 0) chk("read_data_fwft", int'(rd1), int'(q[0]));
      end
   end

   task automatic cyc(input logic wi, input logic ri, input logic ce, input logic [3:0] wd, input logic rn);
      write_increment = wi;
      read_increment = ri;
      clear_errors = ce;
      write_data = wd;
      rst_n = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      chk("rst_count", int'(cnt0), 0);
      chk("rst_flags", int'({empty0, ae0, full0, af0, ovf0, unf0}), 6'b110000);
      chk("rst_read_data", int'(rd0), 0);
      for (int i = 0; i < 32; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 4'(i % 16), 1'b1);
         if (i == 26) chk("af_at_27", int'(af0), 0);
         if (i == 27) chk("af_at_28", int'({af0, cnt0}), int'({1'b1, 6'd28}));
      end
      chk("fill_full", int'({full0, cnt0}), int'({1'b1, 6'd32}));
      cyc(1'b1, 1'b0, 1'b0, 4'h5, 1'b1);
      chk("push_full", int'({ovf0, cnt0}), int'({1'b1, 6'd32}));
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
         chk("drain_data", int'(rd0), i % 16);
      end
      chk("drain_empty", int'(empty0), 1);
      cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
      chk("pop_empty", int'(unf0), 1);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
      chk("clear_both", int'({ovf0, unf0}), 0);
      cyc(1'b0, 1'b1, 1'b1, 4'h0, 1'b1);
      chk("set_beats_clear", int'(unf0), 1);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 4'(i + 3), 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 4'hE, 1'b1);
      chk("simul_mid", int'({cnt0, rd0}), int'({6'd10, 4'h3}));
      for (int i = 0; i < 22; i++) cyc(1'b1, 1'b0, 1'b0, 4'(i), 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 4'h9, 1'b1);
      chk("simul_full", int'(cnt0), 31);
      for (int i = 0; i < 31; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 4'h7, 1'b1);
      chk("simul_empty", int'({cnt0, unf0}), int'({6'd1, 1'b1}));
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 4'hA, 1'b1);
      chk("fwft_first", int'({rd1, empty1}), int'({4'hA, 1'b0}));
      cyc(1'b1, 1'b0, 1'b0, 4'hB, 1'b1);
      chk("fwft_hold", int'(rd1), 4'hA);
      cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
      chk("fwft_next", int'(rd1), 4'hB);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 4'(i), 1'b1);
      chk("pre_reset_count", int'(cnt0), 17);
      cyc(1'b1, 1'b0, 1'b0, 4'hF, 1'b0);
      chk("reset_mid", int'({cnt0, empty0}), int'({6'd0, 1'b1}));
      cyc(1'b1, 1'b0, 1'b0, 4'h3, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
      chk("after_reset_data", int'({rd0, empty0}), int'({4'h3, 1'b1}));
      for (int b = 0; b < 12; b++) begin
         int wp, rp;
         wp = (b % 3 == 0) ? 85 : (b % 3 == 1) ? 15 : 50;
         rp = 100 - wp;
         for (int i = 0; i < 200; i++)
            cyc(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp),
                1'($urandom_range(0, 15) == 0), 4'($urandom), 1'($urandom_range(0, 499) != 0));
      end
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
